// File: rtl/siso_ctrl.sv
// Serializes a WIDTH-bit word LSB-first into an external DEPTH-flop SISO chain and recaptures it from the chain output.
// The captured word is presented with a valid/ready handshake, together with a flag that compares it against the word sent.
module siso_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] din,
  output logic             ser_out,
  input  logic             ser_in,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             match,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] W_C  = CW'(WIDTH);
  localparam logic [CW-1:0] D_C  = CW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH + DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    rx_idx;
  logic [WIDTH-1:0] tx_reg, rx_reg, rx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_reg     <= '0;
      rx_reg     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      match      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start_valid) begin
          tx_reg <= din;
          cnt    <= '0;
          rx_reg <= '0;
        end
        SHIFT: begin
          cnt    <= cnt + CW'(1);
          rx_reg <= rx_nxt;
          // rx_nxt already holds the last bit arriving on this edge
          if (cnt == LAST) begin
            dout       <= rx_nxt;
            match      <= (rx_nxt == tx_reg);
            dout_valid <= 1'b1;
          end
        end
        DONE: if (dout_ready) dout_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    ser_out     = 1'b0;
    rx_nxt      = rx_reg;
    rx_idx      = cnt - D_C;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt < W_C) ser_out = tx_reg[cnt[IW-1:0]];
        // the chain output lags ser_out by DEPTH clocks
        if (cnt >= D_C) rx_nxt[rx_idx[IW-1:0]] = ser_in;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: if (dout_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_siso_ctrl.sv
// Loopback bench: siso_ctrl drives a DEPTH-flop chain whose output returns on ser_in (optionally forced to 0).
// A timeline model tracks each word by clocks elapsed since its accept and is compared every cycle.
module tb_siso_ctrl;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst, start_valid, start_ready, ser_out, ser_in;
  logic         dout_valid, dout_ready, match, busy;
  logic [W-1:0] din, dout;
  logic [D-1:0] chain;
  logic         force0;

  always #10 clk = ~clk;

  always_ff @(posedge clk) chain <= {chain[D-2:0], ser_out};
  assign ser_in = force0 ? 1'b0 : chain[D-1];

  siso_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .din(din), .ser_out(ser_out), .ser_in(ser_in), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .match(match), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // model: a word is in flight for W+D clocks after its accept, then waits for dout_ready
  bit           m_active, m_valid, m_wforce, m_match, seen_valid;
  int           m_e, m_step;
  logic [W-1:0] m_tx, m_dout;
  int           acc_steps[$];
  logic [W-1:0] res_q[$];
  bit           match_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", nm, m_step, act, exp);
    end
  endtask

  task automatic step(input bit sv, input logic [W-1:0] d, input bit dr, input bit r, input bit f);
    logic exp_ser;
    start_valid = sv;
    din         = d;
    dout_ready  = dr;
    rst         = r;
    if (!m_active) force0 = f;
    m_step++;
    if (r) begin
      m_active = 0; m_valid = 0; m_e = 0; m_tx = '0; m_dout = '0; m_match = 0;
    end else if (m_valid) begin
      if (dr) m_valid = 0;
    end else if (m_active) begin
      m_e++;
      if (m_e == W + D) begin
        m_active = 0;
        m_valid  = 1;
        m_dout   = m_wforce ? '0 : m_tx;
        m_match  = (m_dout == m_tx);
      end
    end else if (sv) begin
      m_active = 1; m_e = 0; m_tx = d; m_wforce = force0;
      acc_steps.push_back(m_step);
    end
    @(negedge clk);
    exp_ser = (m_active && m_e < W) ? m_tx[m_e[2:0]] : 1'b0;
    chk("start_ready", 32'(start_ready), 32'(!m_active && !m_valid));
    chk("busy",        32'(busy),        32'(m_active));
    chk("ser_out",     32'(ser_out),     32'(exp_ser));
    chk("dout_valid",  32'(dout_valid),  32'(m_valid));
    chk("dout",        32'(dout),        32'(m_dout));
    chk("match",       32'(match),       32'(m_match));
    if (dout_valid && !seen_valid) begin
      res_q.push_back(dout);
      match_q.push_back(match);
    end
    seen_valid = dout_valid;
  endtask

  initial begin
    int           lat;
    int           nvalid;
    logic [W-1:0] ser_seen;
    force0 = 1'b0;
    chain  = '0;
    for (int i = 0; i < 5; i++) step(0, '0, 0, 1, 0);
    chk("reset_ready", 32'(start_ready), 32'd1);
    chk("reset_valid", 32'(dout_valid),  32'd0);
    chk("reset_dout",  32'(dout),        32'd0);
    chk("reset_busy",  32'(busy),        32'd0);

    // loopback A5 with a busy-time request of 3C held on the input
    step(1, 8'hA5, 0, 0, 0);
    lat = 1;
    ser_seen[0] = ser_out;
    for (int i = 1; i < W; i++) begin
      step(1, 8'h3C, 0, 0, 0);
      lat++;
      ser_seen[i] = ser_out;
    end
    while (!dout_valid && lat < 40) begin
      step(1, 8'h3C, 0, 0, 0);
      lat++;
    end
    chk("a5_serial",  32'(ser_seen), 32'h0A5);
    chk("a5_latency", 32'(lat),      32'd13);
    chk("a5_dout",    32'(dout),     32'h0A5);
    chk("a5_match",   32'(match),    32'd1);
    for (int i = 0; i < 10; i++) step(1, 8'h3C, 0, 0, 0);
    chk("hold_dout",  32'(dout),       32'h0A5);
    chk("hold_valid", 32'(dout_valid), 32'd1);
    step(0, '0, 1, 0, 0);
    chk("release_ready", 32'(start_ready), 32'd1);
    chk("retain_dout",   32'(dout),        32'h0A5);

    // corrupted return path
    step(1, 8'hFF, 1, 0, 1);
    lat = 1;
    while (!dout_valid && lat < 40) begin
      step(0, '0, 0, 0, 1);
      lat++;
    end
    chk("corrupt_dout",  32'(dout),  32'h000);
    chk("corrupt_match", 32'(match), 32'd0);
    step(0, '0, 1, 0, 0);

    // reset while cnt == 5
    step(1, 8'h5A, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, '0, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    chk("midrst_busy",  32'(busy),        32'd0);
    chk("midrst_ser",   32'(ser_out),     32'd0);
    chk("midrst_ready", 32'(start_ready), 32'd1);
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, '0, 1, 0, 0);
      if (dout_valid) nvalid++;
    end
    chk("midrst_novalid", 32'(nvalid), 32'd0);

    // back-to-back with dout_ready held high
    acc_steps.delete();
    res_q.delete();
    match_q.delete();
    step(1, 8'h01, 1, 0, 0);
    for (int i = 0; i < 40; i++) step(acc_steps.size() < 2, 8'h80, 1, 0, 0);
    chk("b2b_count", 32'(res_q.size()), 32'd2);
    if (res_q.size() >= 2 && acc_steps.size() >= 2) begin
      chk("b2b_second_accept", 32'(acc_steps[1] - acc_steps[0] + 1), 32'd15);
      chk("b2b_dout0",  32'(res_q[0]),   32'h001);
      chk("b2b_dout1",  32'(res_q[1]),   32'h080);
      chk("b2b_match0", 32'(match_q[0]), 32'd1);
      chk("b2b_match1", 32'(match_q[1]), 32'd1);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 2) != 0), W'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
